// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use hazard controller for the EX stage operand muxes.
// Keeps a shadow {valid, dest, regwrite, memread} for the instructions in EX and MEM,
// registers the operand-mux selects at the ID->EX edge and raises a one-cycle
// stall/bubble when the instruction in ID needs the result of a load sitting in EX.
module fwd_hazard_ctrl #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_hold,
    input  logic             i_flush,
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_uses_rs,
    input  logic             i_id_uses_rt,
    input  logic [REG_W-1:0] i_id_dest,
    input  logic             i_id_reg_write,
    input  logic             i_id_mem_read,
    output logic [1:0]       o_fwd_a,
    output logic [1:0]       o_fwd_b,
    output logic             o_stall,
    output logic             o_bubble,
    output logic [CNT_W-1:0] o_stall_count
);

    typedef enum logic [0:0] {StRun, StLuStall} state_e;

    // Tracker entries: EX holds the instruction currently in EX, MEM the one ahead of it.
    logic             r_ex_valid;
    logic [REG_W-1:0] r_ex_dest;
    logic             r_ex_reg_write;
    logic             r_ex_mem_read;
    logic             r_mem_valid;
    logic [REG_W-1:0] r_mem_dest;
    logic             r_mem_reg_write;

    logic [1:0]       r_fwd_a;
    logic [1:0]       r_fwd_b;
    logic [CNT_W-1:0] r_stall_count;
    state_e           r_state;
    state_e           w_state_next;

    logic w_ex_prod;
    logic w_mem_prod;
    logic w_ex_match_rs;
    logic w_ex_match_rt;
    logic w_mem_match_rs;
    logic w_mem_match_rt;
    logic w_hazard;
    logic w_stall;
    logic w_bubble;
    logic w_ex_gets_bubble;
    logic [1:0] w_sel_a;
    logic [1:0] w_sel_b;

    // Producer qualification and source matching; $0 never forwards.
    always_comb begin
        w_ex_prod      = r_ex_valid & r_ex_reg_write & (r_ex_dest != '0);
        w_mem_prod     = r_mem_valid & r_mem_reg_write & (r_mem_dest != '0);
        w_ex_match_rs  = w_ex_prod & i_id_uses_rs & (r_ex_dest == i_id_rs);
        w_ex_match_rt  = w_ex_prod & i_id_uses_rt & (r_ex_dest == i_id_rt);
        w_mem_match_rs = w_mem_prod & i_id_uses_rs & (r_mem_dest == i_id_rs);
        w_mem_match_rt = w_mem_prod & i_id_uses_rt & (r_mem_dest == i_id_rt);
        // EX is newer than MEM, so it wins when both write the same register.
        w_sel_a = w_ex_match_rs ? 2'd1 : (w_mem_match_rs ? 2'd2 : 2'd0);
        w_sel_b = w_ex_match_rt ? 2'd1 : (w_mem_match_rt ? 2'd2 : 2'd0);
        // An empty ID slot consumes nothing, so it cannot cause a load-use stall.
        w_hazard = i_id_valid & r_ex_mem_read & (w_ex_match_rs | w_ex_match_rt);
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: LU_STALL re-evaluates exactly like RUN, allowing back-to-back loads.
    always_comb begin
        w_state_next = r_state;
        if (!i_hold) begin
            unique case (r_state)
                StRun, StLuStall: w_state_next = w_stall ? StLuStall : StRun;
                default:          w_state_next = StRun;
            endcase
        end
    end

    // FSM outputs: stall/bubble must be combinational so PC and IF/ID hold on this edge.
    always_comb begin
        w_stall  = 1'b0;
        w_bubble = 1'b0;
        unique case (r_state)
            StRun, StLuStall: begin
                // Flush outranks the hazard; Hold suppresses both.
                w_stall  = w_hazard & ~i_flush & ~i_hold;
                w_bubble = (w_hazard | i_flush) & ~i_hold;
            end
            default: begin
                w_stall  = 1'b0;
                w_bubble = 1'b0;
            end
        endcase
        w_ex_gets_bubble = w_stall | i_flush | ~i_id_valid;
    end

    // Tracker advance: MEM takes EX, EX takes ID or an invalid bubble.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ex_valid      <= 1'b0;
            r_ex_dest       <= '0;
            r_ex_reg_write  <= 1'b0;
            r_ex_mem_read   <= 1'b0;
            r_mem_valid     <= 1'b0;
            r_mem_dest      <= '0;
            r_mem_reg_write <= 1'b0;
        end else if (!i_hold) begin
            r_mem_valid     <= r_ex_valid;
            r_mem_dest      <= r_ex_dest;
            r_mem_reg_write <= r_ex_reg_write;
            if (w_ex_gets_bubble) begin
                r_ex_valid     <= 1'b0;
                r_ex_dest      <= '0;
                r_ex_reg_write <= 1'b0;
                r_ex_mem_read  <= 1'b0;
            end else begin
                r_ex_valid     <= 1'b1;
                r_ex_dest      <= i_id_dest;
                r_ex_reg_write <= i_id_reg_write;
                r_ex_mem_read  <= i_id_mem_read;
            end
        end
    end

    // Operand-mux selects travel with the instruction into EX; a bubble carries 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fwd_a <= 2'd0;
            r_fwd_b <= 2'd0;
        end else if (!i_hold) begin
            r_fwd_a <= w_ex_gets_bubble ? 2'd0 : w_sel_a;
            r_fwd_b <= w_ex_gets_bubble ? 2'd0 : w_sel_b;
        end
    end

    // Saturating count of load-use stall cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_count <= '0;
        end else if (w_stall && !(&r_stall_count)) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign o_fwd_a       = r_fwd_a;
    assign o_fwd_b       = r_fwd_b;
    assign o_stall       = w_stall;
    assign o_bubble      = w_bubble;
    assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed MIPS sequences plus random traffic checked against
// a model of the in-flight instruction history.
module tb_fwd_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hold, flush, id_valid, uses_rs, uses_rt, reg_write, mem_read;
    logic [4:0] rs, rt, dest;
    logic [1:0] fwd_a, fwd_b, s_fwd_a, s_fwd_b;
    logic       stall, bubble, s_stall, s_bubble;
    logic [15:0] cnt;
    logic [1:0]  s_cnt;

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.REG_W(5), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_hold(hold), .i_flush(flush), .i_id_valid(id_valid),
        .i_id_rs(rs), .i_id_rt(rt), .i_id_uses_rs(uses_rs), .i_id_uses_rt(uses_rt),
        .i_id_dest(dest), .i_id_reg_write(reg_write), .i_id_mem_read(mem_read),
        .o_fwd_a(fwd_a), .o_fwd_b(fwd_b), .o_stall(stall), .o_bubble(bubble),
        .o_stall_count(cnt)
    );

    // Same traffic into a 2-bit counter instance to exercise saturation.
    fwd_hazard_ctrl #(.REG_W(5), .CNT_W(2)) dut_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_hold(hold), .i_flush(flush), .i_id_valid(id_valid),
        .i_id_rs(rs), .i_id_rt(rt), .i_id_uses_rs(uses_rs), .i_id_uses_rt(uses_rt),
        .i_id_dest(dest), .i_id_reg_write(reg_write), .i_id_mem_read(mem_read),
        .o_fwd_a(s_fwd_a), .o_fwd_b(s_fwd_b), .o_stall(s_stall), .o_bubble(s_bubble),
        .o_stall_count(s_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Model: the instructions that entered EX one and two cycles ago (age 1 and age 2).
    typedef struct packed {
        logic       v;
        logic [4:0] d;
        logic       rw;
        logic       ld;
    } ins_t;
    ins_t age1, age2;
    int   m_cnt, m_cnt_sat;
    logic [1:0] m_fwd_a, m_fwd_b;
    logic last_stall, last_bubble;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit produces(input ins_t p, input logic [4:0] s, input logic used);
        return used && p.v && p.rw && (p.d != 5'd0) && (p.d == s);
    endfunction

    function automatic logic [1:0] pick(input logic [4:0] s, input logic used);
        if (produces(age1, s, used)) return 2'd1;
        if (produces(age2, s, used)) return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_reset();
        age1 = '0; age2 = '0; m_cnt = 0; m_cnt_sat = 0; m_fwd_a = 2'd0; m_fwd_b = 2'd0;
    endtask

    // One pipeline cycle: drive ID at negedge, check stall/bubble, then registered outputs.
    task automatic step(input logic v, input logic [4:0] s_rs, input logic [4:0] s_rt,
                        input logic urs, input logic urt, input logic [4:0] d,
                        input logic rw, input logic ld, input logic fl, input logic hd);
        bit haz, es, eb, bub;
        @(negedge clk);
        id_valid = v; rs = s_rs; rt = s_rt; uses_rs = urs; uses_rt = urt; dest = d;
        reg_write = rw; mem_read = ld; flush = fl; hold = hd;
        #1;
        haz = v && age1.ld && (produces(age1, s_rs, urs) || produces(age1, s_rt, urt));
        es  = haz && !fl && !hd;
        eb  = (haz || fl) && !hd;
        last_stall = stall; last_bubble = bubble;
        chk("stall", {31'd0, stall}, {31'd0, es});
        chk("bubble", {31'd0, bubble}, {31'd0, eb});
        if (!hd) begin
            bub = es || fl || !v;
            m_fwd_a = bub ? 2'd0 : pick(s_rs, urs);
            m_fwd_b = bub ? 2'd0 : pick(s_rt, urt);
            age2 = age1;
            age1 = bub ? '0 : '{v: 1'b1, d: d, rw: rw, ld: ld};
            if (es) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt_sat < 3) m_cnt_sat++;
            end
        end
        @(posedge clk);
        #1;
        chk("fwd_a", {30'd0, fwd_a}, {30'd0, m_fwd_a});
        chk("fwd_b", {30'd0, fwd_b}, {30'd0, m_fwd_b});
        chk("stall_count", {16'd0, cnt}, m_cnt);
        chk("stall_count_sat", {30'd0, s_cnt}, m_cnt_sat);
    endtask

    // R-type: dest <= rs op rt
    task automatic rop(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
        step(1'b1, a, b, 1'b1, 1'b1, d, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic lw(input logic [4:0] d, input logic [4:0] base);
        step(1'b1, base, 5'd0, 1'b1, 1'b0, d, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic nop();
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; hold = 0; flush = 0; id_valid = 0; rs = 0; rt = 0; uses_rs = 0;
        uses_rt = 0; dest = 0; reg_write = 0; mem_read = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fwd_a", {30'd0, fwd_a}, 0);
        chk("rst_fwd_b", {30'd0, fwd_b}, 0);
        chk("rst_stall", {31'd0, stall}, 0);
        chk("rst_bubble", {31'd0, bubble}, 0);
        chk("rst_count", {16'd0, cnt}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Independent instructions: no forwarding, no stall.
        for (int i = 0; i < 5; i++) rop(5'(10 + i), 5'(20 + i), 5'(25 + i));
        chk("indep_fwd_a", {30'd0, fwd_a}, 0);
        chk("indep_stall", {31'd0, last_stall}, 0);

        // add $3,$1,$2 ; sub $4,$3,$5
        rop(5'd3, 5'd1, 5'd2);
        rop(5'd4, 5'd3, 5'd5);
        chk("exex_fwd_a", {30'd0, fwd_a}, 1);
        chk("exex_fwd_b", {30'd0, fwd_b}, 0);

        // add $3 ; nop ; or $6,$7,$3
        rop(5'd3, 5'd1, 5'd2);
        nop();
        rop(5'd6, 5'd7, 5'd3);
        chk("memex_fwd_b", {30'd0, fwd_b}, 2);

        // add $3 ; add $3 ; and $8,$3,$3  -> newest wins
        rop(5'd3, 5'd1, 5'd2);
        rop(5'd3, 5'd9, 5'd2);
        rop(5'd8, 5'd3, 5'd3);
        chk("prio_fwd_a", {30'd0, fwd_a}, 1);
        chk("prio_fwd_b", {30'd0, fwd_b}, 1);

        // Write $0 then read $0.
        rop(5'd0, 5'd1, 5'd2);
        rop(5'd5, 5'd0, 5'd0);
        chk("zero_fwd_a", {30'd0, fwd_a}, 0);
        chk("zero_fwd_b", {30'd0, fwd_b}, 0);

        // lw $2,0($1) ; add $4,$2,$2 -> one stall, then select 2 on both operands.
        lw(5'd2, 5'd1);
        rop(5'd4, 5'd2, 5'd2);
        chk("lu_stall", {31'd0, last_stall}, 1);
        chk("lu_bubble", {31'd0, last_bubble}, 1);
        chk("lu_count", {16'd0, cnt}, 1);
        rop(5'd4, 5'd2, 5'd2);
        chk("lu_stall_once", {31'd0, last_stall}, 0);
        chk("lu_fwd_a", {30'd0, fwd_a}, 2);
        chk("lu_fwd_b", {30'd0, fwd_b}, 2);

        // Flush beats the hazard.
        lw(5'd2, 5'd1);
        step(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("flush_stall", {31'd0, last_stall}, 0);
        chk("flush_bubble", {31'd0, last_bubble}, 1);
        chk("flush_count", {16'd0, cnt}, 1);
        chk("flush_fsm", 32'(dut.r_state), 0);

        // Hold for 4 cycles mid-hazard, then exactly one stall.
        lw(5'd2, 5'd1);
        repeat (4) step(1'b1, 5'd2, 5'd7, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("hold_count", {16'd0, cnt}, 1);
        rop(5'd4, 5'd2, 5'd7);
        chk("hold_release_stall", {31'd0, last_stall}, 1);
        rop(5'd4, 5'd2, 5'd7);
        chk("hold_after_stall", {31'd0, last_stall}, 0);
        chk("hold_fwd_a", {30'd0, fwd_a}, 2);

        // Five more stalls: 2-bit counter pins at 3.
        for (int i = 0; i < 5; i++) begin
            lw(5'd9, 5'd1);
            rop(5'd10, 5'd1, 5'd9);
            rop(5'd10, 5'd1, 5'd9);
        end
        chk("sat_count", {30'd0, s_cnt}, 3);
        chk("wide_count", {16'd0, cnt}, 7);

        // Reset asserted mid-stall drops Stall immediately.
        lw(5'd2, 5'd1);
        @(negedge clk);
        id_valid = 1; rs = 5'd2; rt = 5'd0; uses_rs = 1; uses_rt = 0; dest = 5'd4;
        reg_write = 1; mem_read = 0; flush = 0; hold = 0;
        #1;
        chk("pre_rst_stall", {31'd0, stall}, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_stall", {31'd0, stall}, 0);
        chk("async_rst_count", {16'd0, cnt}, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic over a small register set to provoke many interactions.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                 1'($urandom), ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Pipeline forwarding and load-use hazard controller for the 32-bit MIPS datapath. It keeps a shadow copy of the destination-register and control information for the EX and MEM stages. From that it generates the 2-bit select codes for the two EX-stage 3:1 operand muxes (ALU input A and input B). It also sequences a one-cycle stall with bubble insertion when a load result is needed by the next instruction. It sits beside the ID/EX pipeline register and is clocked with it.

## Interface
- Parameters:
- REG_W, 5, register-specifier width
- CNT_W, 16, stall-counter width
- Ports:
- Clk  in  1  pipeline clock, rising edge
- Rst  in  1  asynchronous, active-low reset
- Hold  in  1  global freeze (memory wait); all state holds
- Flush  in  1  branch taken; squash the instruction currently in ID
- IdValid  in  1  ID stage holds a real instruction
- IdRs, IdRt  in  REG_W  source specifiers of the ID instruction
- IdUsesRs, IdUsesRt  in  1  ID instruction reads Rs / Rt
- IdDest  in  REG_W  destination specifier of the ID instruction
- IdRegWrite, IdMemRead  in  1  ID instruction writes a register / is a load
- FwdA, FwdB  out  2  EX mux selects: 0 = register file, 1 = EX/MEM ALU result, 2 = MEM/WB write-back value; 3 is never driven
- Stall  out  1  hold PC and IF/ID this cycle
- Bubble  out  1  load NOP into ID/EX this cycle
- StallCount  out  CNT_W  saturating count of load-use stall cycles

## Operation
- Tracker entries for EX and MEM. Each entry holds {valid, dest, regwrite, memread}.
- On each non-held clock edge:
  - MEM is loaded from EX.
  - EX is loaded from ID, or with an invalid bubble when Stall, Flush or !IdValid.
- A producer "matches" source s when all of these hold: entry valid, regwrite = 1, dest ≠ 0, dest == s, and the source is used.
- Forward select for each source (A uses Rs, B uses Rt), computed from the current entries and registered at the ID→EX edge:
  - If the EX entry matches, the select is 1. In the next cycle that producer is in MEM.
  - Otherwise, if the MEM entry matches, the select is 2.
  - Otherwise the select is 0.
  - EX has priority over MEM, because the newest value wins.
  - Register $0 always gives 0.
- Load-use hazard: the EX entry matches Rs or Rt and the EX entry has memread = 1.
- FSM states:
  - RUN. On a load-use hazard with Flush = 0 and Hold = 0, raise Stall and Bubble combinationally and go to LU_STALL at the edge. Stall and Bubble must be combinational in the hazard cycle, because PC and IF/ID must hold on that same edge.
  - LU_STALL lasts one cycle. The load is now in MEM, so the recomputed select is 2. Stall is 0 and the state returns to RUN.
  - A back-to-back hazard against a different load is allowed: LU_STALL re-evaluates exactly like RUN.
- Flush has priority over the hazard: no Stall, Bubble = 1, the state goes to RUN, and FwdA/FwdB load 0.
- When a bubble enters EX, FwdA and FwdB load 0.
- StallCount increments once per cycle in which Stall = 1 and Hold = 0. It saturates at all-ones.
- Hold = 1 freezes the tracker, FSM, FwdA/FwdB and StallCount. Stall and Bubble are forced to 0.

## Timing
- Reset values:
  - FwdA = 0, FwdB = 0
  - Stall = 0, Bubble = 0
  - StallCount = 0
  - both tracker entries invalid
  - FSM = RUN
- FwdA/FwdB are registered. They are valid for the whole cycle in which the matching instruction occupies EX, one cycle after it was in ID.
- Stall/Bubble are combinational from the ID inputs and the tracker state, within the same cycle. They are never asserted while Hold = 1.
- Load-use penalty is exactly 1 cycle. The following operand always gets select 2.
- Reset asserted mid-stall drops Stall immediately (asynchronously) and clears all state.
- Simultaneous Flush and hazard: Flush wins and StallCount is unchanged.
- Simultaneous Hold and Flush: Hold wins. Flush must be re-presented by the datapath.

## Test plan
- Reset: release Rst after 3 cycles. All outputs are 0 and there is no stall for 5 cycles of independent instructions.
- EX→EX forwarding: add $3,$1,$2 followed by sub $4,$3,$5. During the sub's EX cycle FwdA = 1 and FwdB = 0. The sequence add $3 / nop / or $6,$7,$3 gives FwdB = 2.
- Priority and $0:
  - add $3 / add $3 / and $8,$3,$3 gives FwdA = FwdB = 1.
  - A write to $0 followed by a read of $0 gives selects of 0.
- Load-use: lw $2,0($1) followed by add $4,$2,$2.
  - Stall = Bubble = 1 for one cycle.
  - The add then enters EX with FwdA = FwdB = 2.
  - StallCount goes to 1.
- Flush during hazard: lw $2 then beq-taken with Flush = 1 while a $2 user is in ID. Required: Stall = 0, Bubble = 1, StallCount unchanged, FSM in RUN.
- Hold and saturation:
  - Hold high for 4 cycles in mid-hazard: no state change, then exactly one stall cycle after release.
  - With CNT_W = 2, force 5 stalls: StallCount stays at 3.
